// File: rtl/stream_codec_pkg.sv
// Shared definitions for the push_code stream encoder/decoder pair.
// Push-code encodings, a floor-log2 helper and the default-sized LUT entry layout.
package stream_codec_pkg;

    localparam logic [1:0] PUSH_IDLE  = 2'd0;
    localparam logic [1:0] PUSH_DATA  = 2'd1;
    localparam logic [1:0] PUSH_FLUSH = 2'd2;
    localparam logic [1:0] PUSH_LUT   = 2'd3;

    function automatic int unsigned log2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = value; v > 1; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    localparam int unsigned LUT_CODE_LEN = 8;
    localparam int unsigned LUT_LEN_W    = log2(LUT_CODE_LEN) + 1;

    typedef struct packed {
        logic [LUT_LEN_W-1:0]    len;
        logic [LUT_CODE_LEN-1:0] code;
    } lut_entry_t;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with occupancy count, full and half_full flags.
// A push while full is ignored; full is taken from the current count, before any pop.
module stream_fifo #(
    parameter int unsigned Width = 9,
    parameter int unsigned Depth = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             half_full_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CntW'(Depth));
    assign half_full_o = (count_q >= CntW'(Depth / 2));
    assign rdata_o     = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/stream_encoder.sv
// Prefix-code stream encoder: FIFO -> registered LUT read -> bit accumulator -> q register.
// Define STREAM_ENCODER_OVERFLOW_EN to add a sticky overflow output for dropped pushes.
module stream_encoder
    import stream_codec_pkg::*;
#(
    parameter int unsigned WIDTH_IN     = 8,
    parameter int unsigned WIDTH_OUT    = 8,
    parameter int unsigned MAX_CODE_LEN = 8,
    parameter int unsigned FIFO_DEPTH   = 16,
    localparam int unsigned LEN_W       = log2(MAX_CODE_LEN) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    push_code,
    input  logic [WIDTH_IN-1:0]           d,
    input  logic [LEN_W+MAX_CODE_LEN-1:0] lut_d,
    output logic [WIDTH_OUT-1:0]          q,
    output logic                          push_out,
    output logic                          full,
    output logic                          half_full,
    output logic [WIDTH_IN-1:0]           lut_counter,
    input  logic                          stall
`ifdef STREAM_ENCODER_OVERFLOW_EN
    ,
    output logic                          overflow
`endif
);

    localparam int unsigned ACC_W = WIDTH_OUT + MAX_CODE_LEN;
    localparam int unsigned CNT_W = $clog2(ACC_W + 1);
    localparam int unsigned LUT_N = 2 ** WIDTH_IN;
    localparam logic [MAX_CODE_LEN-1:0] CODE_ONES = '1;

    typedef struct packed {
        logic [LEN_W-1:0]        len;
        logic [MAX_CODE_LEN-1:0] code;
    } entry_t;

    entry_t              lut_q [LUT_N];
    logic [WIDTH_IN-1:0] lut_counter_q, lut_counter_d;

    logic                lut_we, push_req, fifo_pop, fifo_empty;
    logic [WIDTH_IN:0]   fifo_rdata;

    logic                p_valid_q, p_valid_d, p_flush_q, p_flush_d;
    entry_t              p_entry_q, p_entry_d;
    logic [ACC_W-1:0]    acc_q, acc_d, acc_sh, code_ext;
    logic [CNT_W-1:0]    bit_count_q, bit_count_d, residual, sh;
    logic [LEN_W-1:0]    len_eff;
    logic [WIDTH_OUT-1:0] q_q, q_d;
    logic                push_out_q, push_out_d;
    logic                emit_full, flush_pad, flush_done, commit, advance;

    stream_fifo #(
        .Width (WIDTH_IN + 1),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst),
        .push_i      (push_req),
        .pop_i       (fifo_pop),
        .wdata_i     ({push_code == PUSH_FLUSH, d}),
        .rdata_o     (fifo_rdata),
        .empty_o     (fifo_empty),
        .full_o      (full),
        .half_full_o (half_full)
    );

    always_comb begin
        lut_we   = 1'b0;
        push_req = 1'b0;
        unique case (push_code)
            PUSH_IDLE:              ;
            PUSH_DATA, PUSH_FLUSH:  push_req = 1'b1;
            PUSH_LUT:               lut_we   = 1'b1;
        endcase
        lut_counter_d = lut_we ? lut_counter_q + 1'b1 : lut_counter_q;
    end

    // Emit and commit share a cycle: the code lands after whatever survives the emit.
    always_comb begin
        emit_full  = !stall && (bit_count_q >= CNT_W'(WIDTH_OUT));
        flush_pad  = !stall && p_valid_q && p_flush_q && (bit_count_q != '0)
                     && (bit_count_q < CNT_W'(WIDTH_OUT));
        acc_sh     = emit_full ? (acc_q << WIDTH_OUT) : acc_q;
        residual   = emit_full ? (bit_count_q - CNT_W'(WIDTH_OUT)) : bit_count_q;
        len_eff    = (p_entry_q.len > LEN_W'(MAX_CODE_LEN)) ? LEN_W'(MAX_CODE_LEN)
                                                            : p_entry_q.len;
        code_ext   = ACC_W'(p_entry_q.code & ~(CODE_ONES << len_eff));
        sh         = CNT_W'(ACC_W) - residual - CNT_W'(len_eff);
        commit     = !stall && p_valid_q && !p_flush_q && (residual <= CNT_W'(WIDTH_OUT));
        flush_done = !stall && p_valid_q && p_flush_q && (residual == '0);
        advance    = !p_valid_q || commit || flush_done || flush_pad;
        fifo_pop   = advance && !fifo_empty;

        acc_d       = acc_sh;
        bit_count_d = residual;
        if (commit) begin
            acc_d       = acc_sh | (code_ext << sh);
            bit_count_d = residual + CNT_W'(len_eff);
        end
        if (flush_pad) begin
            acc_d       = '0;
            bit_count_d = '0;
        end

        q_d        = q_q;
        push_out_d = 1'b0;
        if (emit_full || flush_pad) begin
            q_d        = acc_q[ACC_W-1 -: WIDTH_OUT];
            push_out_d = 1'b1;
        end

        p_valid_d = p_valid_q;
        p_flush_d = p_flush_q;
        p_entry_d = p_entry_q;
        if (advance) begin
            p_valid_d = !fifo_empty;
            p_flush_d = fifo_rdata[WIDTH_IN];
            p_entry_d = lut_q[fifo_rdata[WIDTH_IN-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lut_counter_q <= '0;
            p_valid_q     <= 1'b0;
            p_flush_q     <= 1'b0;
            p_entry_q     <= '0;
            acc_q         <= '0;
            bit_count_q   <= '0;
            q_q           <= '0;
            push_out_q    <= 1'b0;
        end else begin
            lut_counter_q <= lut_counter_d;
            p_valid_q     <= p_valid_d;
            p_flush_q     <= p_flush_d;
            p_entry_q     <= p_entry_d;
            acc_q         <= acc_d;
            bit_count_q   <= bit_count_d;
            q_q           <= q_d;
            push_out_q    <= push_out_d;
        end
    end

    // LUT contents survive reset.
    always_ff @(posedge clk) begin
        if (lut_we) begin
            lut_q[lut_counter_q] <= entry_t'(lut_d);
        end
    end

    assign q           = q_q;
    assign push_out    = push_out_q;
    assign lut_counter = lut_counter_q;

`ifdef STREAM_ENCODER_OVERFLOW_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q || (push_req && full);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_stream_encoder.sv
// Self-checking bench for stream_encoder: directed vectors plus randomized traffic
// compared against a bit-queue reference model.
module tb_stream_encoder;

    localparam int unsigned WIDTH_IN     = 8;
    localparam int unsigned WIDTH_OUT    = 8;
    localparam int unsigned MAX_CODE_LEN = 8;
    localparam int unsigned FIFO_DEPTH   = 16;
    localparam int unsigned LEN_W        = 4;

    logic                          clk = 1'b0;
    logic                          rst = 1'b0;
    logic [1:0]                    push_code = 2'd0;
    logic [WIDTH_IN-1:0]           d = '0;
    logic [LEN_W+MAX_CODE_LEN-1:0] lut_d = '0;
    logic [WIDTH_OUT-1:0]          q;
    logic                          push_out, full, half_full;
    logic [WIDTH_IN-1:0]           lut_counter;
    logic                          stall = 1'b0;
`ifdef STREAM_ENCODER_OVERFLOW_EN
    logic                          overflow;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_encoder #(
        .WIDTH_IN     (WIDTH_IN),
        .WIDTH_OUT    (WIDTH_OUT),
        .MAX_CODE_LEN (MAX_CODE_LEN),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push_code   (push_code),
        .d           (d),
        .lut_d       (lut_d),
        .q           (q),
        .push_out    (push_out),
        .full        (full),
        .half_full   (half_full),
        .lut_counter (lut_counter),
        .stall       (stall)
`ifdef STREAM_ENCODER_OVERFLOW_EN
        ,
        .overflow    (overflow)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: no word may appear after an edge at which stall was high.
    logic           stall_prev = 1'b0;
    logic           mon_en = 1'b0;
    logic [7:0]     dut_words [$];
    always @(posedge clk) stall_prev <= stall;
    always @(negedge clk) begin
        if (rst && stall_prev) chk("stall_no_push", {31'd0, push_out}, 32'd0);
        if (mon_en && push_out) dut_words.push_back(q);
    end

    // Reference model: a plain queue of code bits, cut into 8-bit words MSB-first.
    int         lut_len_m [256];
    logic [7:0] lut_code_m [256];
    bit         mbits [$];
    logic [7:0] exp_words [$];

    task automatic model_take_word();
        logic [7:0] w;
        for (int b = 7; b >= 0; b--) w[b] = mbits.pop_front();
        exp_words.push_back(w);
    endtask

    task automatic model_push(input bit is_flush, input logic [7:0] sym);
        int l;
        if (is_flush) begin
            if (mbits.size() > 0) begin
                while (mbits.size() < 8) mbits.push_back(1'b0);
                model_take_word();
            end
        end else begin
            l = (lut_len_m[sym] > 8) ? 8 : lut_len_m[sym];
            for (int b = l - 1; b >= 0; b--) mbits.push_back(lut_code_m[sym][b]);
            while (mbits.size() >= 8) model_take_word();
        end
    endtask

    typedef struct {
        logic [1:0] pc;
        logic [7:0] sym;
        logic       po;
        logic [7:0] q;
    } vec_t;

    vec_t vecs [$];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, exp_cnt, r, wait_n;
        logic [11:0] ld [4];

        // Back-to-back 2-bit codes, then 3+3 bits closed by a flush.
        vecs.push_back('{2'd1, 8'd1, 1'b0, 8'h00});
        vecs.push_back('{2'd1, 8'd1, 1'b0, 8'h00});
        vecs.push_back('{2'd1, 8'd1, 1'b0, 8'h00});
        vecs.push_back('{2'd1, 8'd1, 1'b0, 8'h00});
        vecs.push_back('{2'd0, 8'd0, 1'b0, 8'h00});
        vecs.push_back('{2'd0, 8'd0, 1'b0, 8'h00});
        vecs.push_back('{2'd0, 8'd0, 1'b1, 8'hAA});
        vecs.push_back('{2'd0, 8'd0, 1'b0, 8'hAA});
        vecs.push_back('{2'd1, 8'd2, 1'b0, 8'hAA});
        vecs.push_back('{2'd1, 8'd3, 1'b0, 8'hAA});
        vecs.push_back('{2'd2, 8'd0, 1'b0, 8'hAA});
        vecs.push_back('{2'd0, 8'd0, 1'b0, 8'hAA});
        vecs.push_back('{2'd0, 8'd0, 1'b1, 8'hDC});
        vecs.push_back('{2'd0, 8'd0, 1'b0, 8'hDC});

        ld[0] = {4'd1, 8'b0};
        ld[1] = {4'd2, 8'b10};
        ld[2] = {4'd3, 8'b110};
        ld[3] = {4'd3, 8'b111};

        repeat (2) step();
        chk("reset_q", {24'd0, q}, 32'd0);
        chk("reset_push_out", {31'd0, push_out}, 32'd0);
        chk("reset_full", {31'd0, full}, 32'd0);
        chk("reset_half_full", {31'd0, half_full}, 32'd0);
        chk("reset_lut_counter", {24'd0, lut_counter}, 32'd0);
`ifdef STREAM_ENCODER_OVERFLOW_EN
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
`endif
        rst = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            push_code = 2'd3;
            lut_d = ld[i];
            step();
        end
        push_code = 2'd0;
        chk("lut_counter_after_load", {24'd0, lut_counter}, 32'd4);

        foreach (vecs[i]) begin
            push_code = vecs[i].pc;
            d = vecs[i].sym;
            step();
            chk($sformatf("vec%0d_push_out", i), {31'd0, push_out}, {31'd0, vecs[i].po});
            chk($sformatf("vec%0d_q", i), {24'd0, q}, {24'd0, vecs[i].q});
        end
        push_code = 2'd0;

        // Leave a 3-bit partial word, then reset asynchronously between edges.
        push_code = 2'd1;
        d = 8'd2;
        step();
        push_code = 2'd0;
        repeat (3) step();
        #2 rst = 1'b0;
        #1;
        chk("async_reset_q", {24'd0, q}, 32'd0);
        chk("async_reset_push_out", {31'd0, push_out}, 32'd0);
        chk("async_reset_full", {31'd0, full}, 32'd0);
        chk("async_reset_lut_counter", {24'd0, lut_counter}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        push_code = 2'd2;
        step();
        push_code = 2'd0;
        cnt = 0;
        repeat (10) begin
            step();
            if (push_out) cnt++;
        end
        chk("flush_after_reset_words", cnt, 32'd0);

        // Stall with 20 one-bit pushes: one sits in the pipeline, 16 fill the FIFO.
        stall = 1'b1;
        for (int k = 0; k < 20; k++) begin
            push_code = 2'd1;
            d = 8'd0;
            step();
            exp_cnt = (k == 0) ? 1 : ((k < 16) ? k : 16);
            chk($sformatf("stall_full_k%0d", k), {31'd0, full}, {31'd0, exp_cnt == 16});
            chk($sformatf("stall_half_k%0d", k), {31'd0, half_full}, {31'd0, exp_cnt >= 8});
`ifdef STREAM_ENCODER_OVERFLOW_EN
            chk($sformatf("stall_overflow_k%0d", k), {31'd0, overflow}, {31'd0, k >= 17});
`endif
        end
        push_code = 2'd0;
        stall = 1'b0;
        cnt = 0;
        repeat (60) begin
            step();
            if (push_out) begin
                cnt++;
                chk("drain_word_q", {24'd0, q}, 32'd0);
            end
        end
        chk("drain_word_count", cnt, 32'd2);
        chk("drain_full", {31'd0, full}, 32'd0);
        push_code = 2'd2;
        step();
        push_code = 2'd0;
        cnt = 0;
        repeat (10) begin
            step();
            if (push_out) begin
                cnt++;
                chk("tail_word_q", {24'd0, q}, 32'd0);
            end
        end
        chk("tail_word_count", cnt, 32'd1);
`ifdef STREAM_ENCODER_OVERFLOW_EN
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);
`endif

        // Full LUT reload with random entries; the write pointer wraps.
        for (int i = 0; i < 256; i++) begin
            lut_len_m[i] = int'($urandom_range(0, 12));
            lut_code_m[i] = 8'($urandom);
            push_code = 2'd3;
            lut_d = {4'(lut_len_m[i]), lut_code_m[i]};
            step();
            if (i == 0) chk("lut_counter_first", {24'd0, lut_counter}, 32'd1);
        end
        push_code = 2'd0;
        chk("lut_counter_wrap", {24'd0, lut_counter}, 32'd0);

        #2 rst = 1'b0;
        #1;
`ifdef STREAM_ENCODER_OVERFLOW_EN
        chk("overflow_cleared", {31'd0, overflow}, 32'd0);
`endif
        chk("reset2_push_out", {31'd0, push_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        mbits.delete();
        exp_words.delete();
        dut_words.delete();
        mon_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 99));
            push_code = 2'd0;
            if (!full && r < 75) begin
                push_code = 2'd1;
                d = 8'($urandom);
                model_push(1'b0, d);
            end else if (!full && r < 80) begin
                push_code = 2'd2;
                d = 8'($urandom);
                model_push(1'b1, d);
            end
            step();
        end
        push_code = 2'd0;
        stall = 1'b0;
        wait_n = 0;
        while (full && wait_n < 100) begin
            step();
            wait_n++;
        end
        push_code = 2'd2;
        model_push(1'b1, 8'd0);
        step();
        push_code = 2'd0;
        wait_n = 0;
        while (dut_words.size() < exp_words.size() && wait_n < 2000) begin
            step();
            wait_n++;
        end
        repeat (20) step();
        mon_en = 1'b0;
        chk("random_word_count", dut_words.size(), exp_words.size());
        for (int i = 0; i < exp_words.size() && i < dut_words.size(); i++) begin
            chk($sformatf("random_word%0d", i), {24'd0, dut_words[i]}, {24'd0, exp_words[i]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
